// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: PC register and IF/ID pipeline register with redirect, back-pressure and misaligned-PC fault.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        jump,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        ifid_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus_4,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        run, adv, load, bad, capture;
    always_comb begin
        run           = state_q == RUN;
        adv           = run && !stall && (!ifid_valid_q || ifid_ready);
        load          = run && (jump || adv);
        bad           = next_pc[1:0] != 2'b00;
        capture       = adv && !jump && !bad;
        state_d       = state_q == BOOT ? RUN : (load && bad) ? FAULT : state_q;
        pc_d          = (load && !bad) ? next_pc : pc_q;
        ifid_valid_d  = load ? capture : ifid_valid_q;
        ifid_pc_d     = capture ? pc_q : ifid_pc_q;
        ifid_instr_d  = capture ? imem_rdata : ifid_instr_q;
        // an entry squashed by a redirect in the same cycle is not counted
        fetch_count_d = (run && ifid_valid_q && ifid_ready && !jump) ? fetch_count_q + 32'd1 : fetch_count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 32'd0;
            ifid_instr_q  <= 32'd0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end
    assign imem_addr   = pc_q;
    assign pc_plus_4   = pc_q + 32'd4;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fault       = state_q == FAULT;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed fetch-stage vectors; accepted IF/ID entries are checked against a scoreboard queue.
module tb_pc_fetch_stage;
    logic        clk = 0, reset = 1, jump = 0, stall = 0, ifid_ready = 0, seq = 0;
    logic [31:0] tgt = 0, next_pc, imem_rdata, imem_addr, pc_plus_4, ifid_pc, ifid_instr, fetch_count;
    logic        ifid_valid, fault;
    int          nchk = 0, nerr = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign next_pc    = seq ? pc_plus_4 : tgt;
    assign imem_rdata = mem(imem_addr);

    pc_fetch_stage dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .jump(jump), .stall(stall),
        .imem_rdata(imem_rdata), .ifid_ready(ifid_ready), .imem_addr(imem_addr),
        .pc_plus_4(pc_plus_4), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid), .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string name, input logic [31:0] pc, input logic v, input logic [31:0] ipc,
                      input logic f, input logic [31:0] cnt);
        chk({name, " pc"}, imem_addr, pc);
        chk({name, " pc4"}, pc_plus_4, pc + 32'd4);
        chk({name, " valid"}, {31'd0, ifid_valid}, {31'd0, v});
        if (v) begin
            chk({name, " ifid_pc"}, ifid_pc, ipc);
            chk({name, " ifid_instr"}, ifid_instr, mem(ipc));
        end
        chk({name, " fault"}, {31'd0, fault}, {31'd0, f});
        chk({name, " count"}, fetch_count, cnt);
    endtask

    task automatic rst_vals(input string name);
        st(name, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk({name, " ifid_pc0"}, ifid_pc, 32'h0);
        chk({name, " ifid_instr0"}, ifid_instr, 32'h0);
    endtask

    // monitor: every entry decode accepts must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && ifid_valid && ifid_ready && !jump) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected: got pc %h expected none", ifid_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", ifid_pc, e);
                chk("sb_instr", ifid_instr, mem(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        rst_vals("reset");
        reset = 0; seq = 1; ifid_ready = 1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick(); st("boot", 32'h0, 0, 0, 0, 0);
        tick(); st("seq1", 32'h4, 1, 32'h0, 0, 0);
        tick(); st("seq2", 32'h8, 1, 32'h4, 0, 1);
        tick(); st("seq3", 32'hC, 1, 32'h8, 0, 2);
        tick(); st("seq4", 32'h10, 1, 32'hC, 0, 3);
        ifid_ready = 0;
        repeat (3) begin
            tick(); st("bp_hold", 32'h10, 1, 32'hC, 0, 3);
        end
        ifid_ready = 1;
        tick(); st("bp_resume", 32'h14, 1, 32'h10, 0, 4);
        stall = 1; jump = 1; seq = 0; tgt = 32'h100;
        tick(); st("jmp_stall", 32'h100, 0, 0, 0, 4);
        stall = 0; jump = 0; seq = 1;
        exp_q.push_back(32'h100);
        tick(); st("jmp_fetch", 32'h104, 1, 32'h100, 0, 4);
        tick(); st("jmp_next", 32'h108, 1, 32'h104, 0, 5);
        jump = 1; seq = 0; tgt = 32'h102;
        tick(); st("misalign", 32'h108, 0, 0, 1, 5);
        jump = 0; stall = 1; ifid_ready = 0; tgt = 32'h200;
        tick(); st("fault_hold1", 32'h108, 0, 0, 1, 5);
        jump = 1; stall = 0; ifid_ready = 1;
        tick(); st("fault_hold2", 32'h108, 0, 0, 1, 5);
        jump = 0; reset = 1;
        repeat (3) begin
            tick(); rst_vals("fault_reset");
        end
        reset = 0; seq = 1;
        tick(); st("boot2", 32'h0, 0, 0, 0, 0);
        jump = 1; seq = 0; tgt = 32'hFFFF_FFFC;
        tick(); st("wrap_pc", 32'hFFFF_FFFC, 0, 0, 0, 0);
        chk("wrap_pc4", pc_plus_4, 32'h0);
        jump = 0; seq = 1;
        exp_q.push_back(32'hFFFF_FFFC);
        tick(); st("wrap_adv", 32'h0, 1, 32'hFFFF_FFFC, 0, 0);
        tick(); st("wrap_next", 32'h4, 1, 32'h0, 0, 1);
        stall = 1; ifid_ready = 0;
        tick(); st("stall_hold", 32'h4, 1, 32'h0, 0, 1);
        reset = 1;
        tick(); rst_vals("mid_reset");
        reset = 0; stall = 0; seq = 0; tgt = 32'h0000_0041;
        tick(); st("boot3", 32'h0, 0, 0, 0, 0);
        tick(); st("adv_misalign", 32'h0, 0, 0, 1, 0);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
